// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB with 2-bit direction counters and flush sweep
module branch_target_buffer #(
    parameter int NUM_ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] fetch_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        update_btb,
    input  logic [31:0] update_pc,
    input  logic        branch_outcome,
    input  logic [31:0] branch_target,
    output logic        busy
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q    [NUM_ENTRIES];
    logic [TAG_W-1:0]       tag_d    [NUM_ENTRIES];
    logic [31:0]            target_q [NUM_ENTRIES];
    logic [31:0]            target_d [NUM_ENTRIES];
    logic [1:0]             ctr_q    [NUM_ENTRIES];
    logic [1:0]             ctr_d    [NUM_ENTRIES];

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             u_hit;
    logic             unused_pc_bits;

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[31:IDX_W+2];
    assign u_idx = update_pc[IDX_W+1:2];
    assign u_tag = update_pc[31:IDX_W+2];
    assign unused_pc_bits = ^update_pc[1:0];

    assign busy        = (state_q == CLEAR);
    assign pred_hit    = !busy && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken  = pred_hit && ctr_q[f_idx][1];
    assign pred_target = pred_taken ? target_q[f_idx] : fetch_pc + 32'd4;
    assign u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        case (state_q)
            IDLE: begin
                // flush takes priority; a coincident update is dropped
                if (flush) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end else if (update_btb) begin
                    if (u_hit) begin
                        if (branch_outcome) begin
                            target_d[u_idx] = branch_target;
                            if (ctr_q[u_idx] != 2'b11)
                                ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
                        end else if (ctr_q[u_idx] != 2'b00) begin
                            ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
                        end
                    end else if (branch_outcome) begin
                        valid_d[u_idx]  = 1'b1;
                        tag_d[u_idx]    = u_tag;
                        target_d[u_idx] = branch_target;
                        ctr_d[u_idx]    = 2'b10;
                    end
                end
            end
            CLEAR: begin
                valid_d[ptr_q] = 1'b0;
                ptr_d          = ptr_q + IDX_W'(1);
                if (ptr_q == IDX_W'(NUM_ENTRIES - 1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
        end
    end

    // payload is only meaningful behind a valid bit, so it carries no reset
    always_ff @(posedge CLK) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        ctr_q    <= ctr_d;
    end
endmodule
